// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter.
// FSM states and grant-side encoding.
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_gnt_t;

endpackage

// File: rtl/mem_port_arbiter_perf.sv
// Grant and conflict event counters for the arbiter.
// All counters wrap at 2^32 and clear on reset.
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        gnt_i,
  input  logic        gnt_d,
  input  logic        conflict,
  output logic [31:0] perf_i_gnt,
  output logic [31:0] perf_d_gnt,
  output logic [31:0] perf_conflict
);

  // count each grant event and each contended idle cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_i_gnt    <= '0;
      perf_d_gnt    <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt_i)
        perf_i_gnt <= perf_i_gnt + 32'd1;
      if (gnt_d)
        perf_d_gnt <= perf_d_gnt + 32'd1;
      if (conflict)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D).
// Optional counters when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_resp,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_i_gnt,
  output logic [31:0]         perf_d_gnt,
  output logic [31:0]         perf_conflict
`endif
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_t          state, state_n;
  arb_gnt_t            last_gnt, last_n;
  logic                read_n, write_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n;
  logic [MASK_W-1:0]   wmask_n;
  logic                d_req;
  logic                gnt_i, gnt_d;
  logic                conflict;

  assign d_req    = d_read | d_write;
  assign conflict = (state == IDLE) & i_read & d_req;

  // grant decision, next state and next mem_* register values
  always_comb begin
    state_n = state;
    last_n  = last_gnt;
    read_n  = mem_read;
    write_n = mem_write;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    wmask_n = mem_wmask;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (conflict) begin
          gnt_d = (last_gnt == GNT_I);
          gnt_i = (last_gnt == GNT_D);
        end else begin
          gnt_i = i_read;
          gnt_d = d_req & ~i_read;
        end
        if (gnt_i) begin
          state_n = BUSY_I;
          read_n  = 1'b1;
          write_n = 1'b0;
          addr_n  = i_addr;
          wdata_n = '0;
          wmask_n = '1;
        end
        if (gnt_d) begin
          state_n = BUSY_D;
          read_n  = ~d_write;
          write_n = d_write;
          addr_n  = d_addr;
          wdata_n = d_write ? d_wdata : '0;
          wmask_n = d_write ? d_wmask : '1;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          state_n = IDLE;
          read_n  = 1'b0;
          write_n = 1'b0;
          last_n  = GNT_I;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          state_n = IDLE;
          read_n  = 1'b0;
          write_n = 1'b0;
          last_n  = GNT_D;
        end
      end
      default: begin
        state_n = IDLE;
        read_n  = 1'b0;
        write_n = 1'b0;
      end
    endcase
  end

  // state, grant history and registered memory request
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= GNT_I;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      state     <= state_n;
      last_gnt  <= last_n;
      mem_read  <= read_n;
      mem_write <= write_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_wmask <= wmask_n;
    end
  end

  assign i_resp  = (state == BUSY_I) & mem_resp;
  assign d_resp  = (state == BUSY_D) & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .gnt_i         (gnt_i),
    .gnt_d         (gnt_d),
    .conflict      (conflict),
    .perf_i_gnt    (perf_i_gnt),
    .perf_d_gnt    (perf_d_gnt),
    .perf_conflict (perf_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default build).
// Vector table of transactions plus hand-written corner sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int passed = 0;
  int total  = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_read;
    logic [31:0] i_addr;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] rdata;
    logic        exp_d;
    logic        exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // both pending each time in 0-3 and 8-9: grants alternate D,I,D,I
    tv[0] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'hF,
              32'h0000AAAA, 1'b1, 1'b1, 32'h200, 32'h11223344, 4'hF};
    tv[1] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'hF,
              32'h12345678, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF};
    tv[2] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h204, 32'h0, 4'h0,
              32'hA5A5A5A5, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF};
    tv[3] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h204, 32'h0, 4'h0,
              32'h5A5A5A5A, 1'b0, 1'b0, 32'h44, 32'h0, 4'hF};
    tv[4] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
              32'h00000013, 1'b0, 1'b0, 32'h60, 32'h0, 4'hF};
    tv[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3,
              32'h0000BEEF, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3};
    tv[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 4'hC,
              32'h00000001, 1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 4'hC};
    tv[7] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h108, 32'h0, 4'h0,
              32'hFEEDFACE, 1'b1, 1'b0, 32'h108, 32'h0, 4'hF};
    tv[8] = '{1'b1, 32'h48, 1'b1, 1'b0, 32'h10C, 32'h0, 4'h0,
              32'h0BADF00D, 1'b0, 1'b0, 32'h48, 32'h0, 4'hF};
    tv[9] = '{1'b1, 32'h4C, 1'b1, 1'b0, 32'h10C, 32'h0, 4'h0,
              32'h87654321, 1'b1, 1'b0, 32'h10C, 32'h0, 4'hF};

    rst       = 1'b0;
    i_read    = 1'b1;
    i_addr    = 32'h40;
    d_read    = 1'b0;
    d_write   = 1'b1;
    d_addr    = 32'h200;
    d_wdata   = 32'h11223344;
    d_wmask   = 4'hF;
    mem_rdata = 32'h0;
    mem_resp  = 1'b0;

    // reset held with requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_resp", {30'b0, i_resp, d_resp}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 10; k++) begin
      i_read   = tv[k].i_read;
      i_addr   = tv[k].i_addr;
      d_read   = tv[k].d_read;
      d_write  = tv[k].d_write;
      d_addr   = tv[k].d_addr;
      d_wdata  = tv[k].d_wdata;
      d_wmask  = tv[k].d_wmask;
      mem_resp = 1'b0;
      cyc();
      chk($sformatf("v%0d_read", k), {31'b0, mem_read},
          {31'b0, ~tv[k].exp_wr});
      chk($sformatf("v%0d_write", k), {31'b0, mem_write},
          {31'b0, tv[k].exp_wr});
      chk($sformatf("v%0d_addr", k), mem_addr, tv[k].exp_addr);
      chk($sformatf("v%0d_wmask", k), {28'b0, mem_wmask},
          {28'b0, tv[k].exp_wmask});
      if (tv[k].exp_wr)
        chk($sformatf("v%0d_wdata", k), mem_wdata, tv[k].exp_wdata);
      chk($sformatf("v%0d_early_resp", k), {30'b0, i_resp, d_resp}, 32'd0);
      mem_resp  = 1'b1;
      mem_rdata = tv[k].rdata;
      #1;
      chk($sformatf("v%0d_i_resp", k), {31'b0, i_resp},
          {31'b0, ~tv[k].exp_d});
      chk($sformatf("v%0d_d_resp", k), {31'b0, d_resp},
          {31'b0, tv[k].exp_d});
      chk($sformatf("v%0d_i_rdata", k), i_rdata,
          tv[k].exp_d ? 32'h0 : tv[k].rdata);
      chk($sformatf("v%0d_d_rdata", k), d_rdata,
          tv[k].exp_d ? tv[k].rdata : 32'h0);
      cyc();
      mem_resp = 1'b0;
      chk($sformatf("v%0d_idle_gap", k), {30'b0, mem_read, mem_write},
          32'd0);
    end

    // I drops its request while busy; grant and address are held
    i_read  = 1'b1;
    i_addr  = 32'h80;
    d_read  = 1'b0;
    d_write = 1'b0;
    cyc();
    i_read = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("hold_read", {31'b0, mem_read}, 32'd1);
      chk("hold_addr", mem_addr, 32'h80);
      cyc();
    end
    mem_resp  = 1'b1;
    mem_rdata = 32'h55;
    #1;
    chk("drop_i_resp", {31'b0, i_resp}, 32'd1);
    chk("drop_i_rdata", i_rdata, 32'h55);
    cyc();
    mem_resp = 1'b0;
    chk("drop_idle", {30'b0, mem_read, mem_write}, 32'd0);

    // reset while D is in flight, then a late memory response
    d_read = 1'b1;
    d_addr = 32'h300;
    cyc();
    chk("midrst_busy", {31'b0, mem_read}, 32'd1);
    rst = 1'b0;
    cyc();
    chk("midrst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    rst       = 1'b1;
    d_read    = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 32'h77;
    #1;
    chk("late_resp", {30'b0, i_resp, d_resp}, 32'd0);
    chk("late_rdata", d_rdata, 32'd0);
    cyc();
    mem_resp = 1'b0;
    chk("late_idle", {30'b0, mem_read, mem_write}, 32'd0);

    // first tie after reset goes to D even though D was last granted
    i_read = 1'b1;
    i_addr = 32'h90;
    d_read = 1'b1;
    d_addr = 32'h310;
    cyc();
    chk("tie_after_rst_addr", mem_addr, 32'h310);
    mem_resp  = 1'b1;
    mem_rdata = 32'h99;
    #1;
    chk("tie_after_rst_d", {30'b0, i_resp, d_resp}, 32'd1);
    cyc();
    mem_resp = 1'b0;
    i_read   = 1'b0;
    d_read   = 1'b0;
    cyc();

    // stray response in IDLE
    mem_resp  = 1'b1;
    mem_rdata = 32'h1234;
    #1;
    chk("stray_resp", {30'b0, i_resp, d_resp}, 32'd0);
    chk("stray_rdata", i_rdata | d_rdata, 32'd0);
    cyc();
    mem_resp = 1'b0;
    chk("stray_strobes", {30'b0, mem_read, mem_write}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
